uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver, 8N1, LSB first. It is the receive half paired with the existing UART transmitter and shares its baud divider. It synchronises the `Rx` pin, detects and validates the start bit, and samples 8 data bits and the stop bit at mid-bit. Each received byte is presented with a one-cycle strobe, and a framing-error pulse is raised on a bad stop bit.

## Interface
- `BAUD_DIVIDER`, default 104: `clk` cycles per bit (12 MHz / 115200). Legal range is ≥ 4.
- `clk`  in  1  reference clock; all logic on rising edge.
- `rstn`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `Rx`  in  1  serial input pin; idle high; asynchronous to `clk`.
- `O_DATA`  out  8  last correctly received byte.
- `NrD`  out  1  new received data; one-cycle pulse.
- `FE`  out  1  framing error; one-cycle pulse.
- `RiP`  out  1  reception in progress; high in any state other than IDLE.

## Operation
- `Rx` passes through a 2-FF synchroniser to produce `rx_s`. A third flop produces `rx_d` for edge detection.
- The block has four states: IDLE, START, DATA, STOP.
  - IDLE → START on a falling edge (`rx_d`=1, `rx_s`=0). `baud_cnt` clears to 0.
  - START: sample at `baud_cnt` = `BAUD_DIVIDER/2` (floor).
    - Sample = 1: false start. Return to IDLE with no output change.
    - Sample = 0: go to DATA, clear `baud_cnt`, and set `bit_cnt` = 0.
  - DATA: sample at `baud_cnt` = `BAUD_DIVIDER`−1 (mid-bit).
    - Each sample shifts into `shreg` from the MSB side, so the LSB arrives first.
    - `baud_cnt` wraps to 0 on every sample.
    - After the sample with `bit_cnt` = 7, go to STOP.
  - STOP: sample at `baud_cnt` = `BAUD_DIVIDER`−1, then return to IDLE.
    - Sample = 1: `O_DATA` ← `shreg` and `NrD` = 1 for the next cycle.
    - Sample = 0: `FE` = 1 for the next cycle and `O_DATA` keeps its value.
- Counter widths:
  - `baud_cnt` is `$clog2(BAUD_DIVIDER)` bits.
  - `bit_cnt` is 3 bits and wraps from 7 to 0 unused.
- Break condition (line held low): after an FE the block is in IDLE with the line low. No edge means no retrigger, so it rearms only after the line returns high.
- Back-to-back frames: IDLE is entered at mid-stop, so a start edge immediately after the stop bit is caught.
- `NrD` and `FE` are never high in the same cycle. Neither can repeat on consecutive cycles.

## Timing
- Reset values: `O_DATA` = 0x00, `NrD` = 0, `FE` = 0, `RiP` = 0. Also state = IDLE, all counters 0, synchroniser flops = 1.
- Reset asserted mid-frame aborts immediately. No partial byte is ever output.
- Reference point: cycle 0 is the first rising edge at which the first synchroniser flop captures `Rx` low.
  - START is entered at cycle 2.
  - Start is checked at cycle 2 + `BAUD_DIVIDER/2`.
  - Data bit k is sampled `BAUD_DIVIDER`·(k+1) cycles after that.
- `NrD`/`FE` rise at cycle 3 + `BAUD_DIVIDER/2` + 9·`BAUD_DIVIDER`. For the default divider that is cycle 991.
- `RiP` is high from cycle 2 until the cycle `NrD`/`FE` is asserted, inclusive of the return to IDLE.

## Configuration
- `UART_RX_MAJORITY_EN`
  - Defined: each start, data and stop decision is a 2-of-3 majority of `rx_s` at mid−1, mid and mid+1. The decision is taken one cycle later than without the macro, so all latencies grow by 1 (`NrD` at cycle 992 for default).
  - Undefined: single sample at mid-bit as described in Operation.

## Structure
- Shared package `uart_pkg`:
  - state encoding localparams `RX_IDLE`=2'b00, `RX_START`=2'b01, `RX_DATA`=2'b10, `RX_STOP`=2'b11;
  - default divider `UART_BAUD_DIVIDER`=104.
- Sub-module `rx_sync`: the 2-FF synchroniser plus edge-detect flop.
  - Reset to 1.
  - Outputs `rx_s` and `fall`.
- FSM, counters and shift register live in `uart_rx`.

## Test plan
- Frame 0x55 with valid stop → `O_DATA` = 0x55 and one `NrD` pulse at cycle 991. `FE` stays 0 and `RiP` falls after the pulse.
- 20-cycle low glitch on idle line → no `NrD`/`FE`, `RiP` high only ~52 cycles, back to IDLE. A following 0xA5 frame is received correctly.
- Frame 0xA3 with stop bit = 0 → `FE` pulse at cycle 991, `O_DATA` keeps its prior value (0x55). The line is held low 3 frames and produces no further events.
- 0x00 immediately followed by 0xFF with zero idle gap → two `NrD` pulses, `O_DATA` 0x00 then 0xFF.
- `rstn` low for 3 cycles during data bit 4 → all outputs at reset values. The next frame 0x3C gives `O_DATA` = 0x3C.
- With `UART_RX_MAJORITY_EN`: 1-cycle inverted glitch at mid-sample of bit 2 in frame 0x81 → `O_DATA` = 0x81 at cycle 992.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: receiver state encoding and default baud divider.
package uart_pkg;

    // Receiver FSM states.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'b00,
        RX_START = 2'b01,
        RX_DATA  = 2'b10,
        RX_STOP  = 2'b11
    } rx_state_t;

    // 12 MHz reference clock / 115200 baud.
    localparam int UART_BAUD_DIVIDER = 104;

endpackage

// File: rtl/rx_sync.sv
// Input conditioning for the UART receiver.
// This module brings the asynchronous Rx pin into the clk domain and flags
// falling edges on it.
//
// When UART_RX_MAJORITY_EN is defined, rx_s is a 2-of-3 vote over three
// consecutive synchronised samples. The vote is centred on the middle sample,
// so the line is seen one cycle later than in the default build.
module rx_sync (
    input  logic clk,
    input  logic rstn,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic rx_d;

`ifdef UART_RX_MAJORITY_EN
    logic hist0;
    logic hist1;
    logic vote;

    assign vote = (sync2 & hist0) | (sync2 & hist1) | (hist0 & hist1);

    // Synchroniser, two-sample history, and the delayed vote used for edge detection; idle-high reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist0 <= 1'b1;
            hist1 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            hist0 <= sync2;
            hist1 <= hist0;
            rx_d  <= vote;
        end
    end

    assign rx_s = vote;
`else
    // Two-flop synchroniser plus one delay flop for edge detection; idle-high reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            rx_d  <= sync2;
        end
    end

    assign rx_s = sync2;
`endif

    assign fall = rx_d & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, mid-bit sampling.
// The receiver shares its baud divider with the paired transmitter.
//
// Each good byte is presented on O_DATA together with a one-cycle NrD pulse.
// A bad stop bit gives a one-cycle FE pulse and leaves O_DATA unchanged.
//
// Optional feature: define UART_RX_MAJORITY_EN to take every bit decision as
// a 2-of-3 vote around mid-bit. This adds one cycle of latency to every event.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIVIDER = UART_BAUD_DIVIDER
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       Rx,
    output logic [7:0] O_DATA,
    output logic       NrD,
    output logic       FE,
    output logic       RiP
);

    localparam int CNT_W = $clog2(BAUD_DIVIDER);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(BAUD_DIVIDER / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIVIDER - 1);

    rx_state_t        state;
    rx_state_t        state_n;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] baud_n;
    logic [2:0]       bit_cnt;
    logic [2:0]       bit_n;
    logic [7:0]       shreg;
    logic [7:0]       shreg_n;
    logic [7:0]       data_n;
    logic             nrd_n;
    logic             fe_n;
    logic             rx_s;
    logic             fall;

    rx_sync u_sync (
        .clk  (clk),
        .rstn (rstn),
        .rx   (Rx),
        .rx_s (rx_s),
        .fall (fall)
    );

    // Register the FSM state, counters, shift register and outputs.
    // Reset aborts any frame in progress at once, so no partial byte is output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= RX_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            O_DATA   <= '0;
            NrD      <= 1'b0;
            FE       <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            O_DATA   <= data_n;
            NrD      <= nrd_n;
            FE       <= fe_n;
        end
    end

    // Next-state logic. Start is checked at half a bit; data and stop bits are
    // sampled one full bit period later. IDLE is re-entered at mid-stop, so a
    // start edge that follows straight after the stop bit is still caught.
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt + 1'b1;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        data_n  = O_DATA;
        nrd_n   = 1'b0;
        fe_n    = 1'b0;
        case (state)
            RX_IDLE: begin
                baud_n = '0;
                if (fall) begin
                    state_n = RX_START;
                end
            end
            RX_START: begin
                if (baud_cnt == HALF) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (baud_cnt == LAST) begin
                    baud_n  = '0;
                    shreg_n = {rx_s, shreg[7:1]};
                    bit_n   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (baud_cnt == LAST) begin
                    baud_n  = '0;
                    state_n = RX_IDLE;
                    if (rx_s) begin
                        data_n = shreg;
                        nrd_n  = 1'b1;
                    end else begin
                        fe_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = RX_IDLE;
            end
        endcase
    end

    // RiP stays high through the cycle that carries the NrD/FE strobe.
    assign RiP = (state != RX_IDLE) | NrD | FE;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (default divider of 104).
// The reference model predicts every frame from line-level rules:
//   - a strobe follows the first captured start-bit low by 3 + DIV/2 + 9*DIV cycles;
//   - the strobe is NrD for a high stop bit and FE for a low one;
//   - O_DATA holds the last byte that had a good stop bit.
module tb_uart_rx;

    localparam int DIV = 104;
`ifdef UART_RX_MAJORITY_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int EV_LAT = 3 + DIV / 2 + 9 * DIV + EXTRA;

    logic       clk  = 1'b0;
    logic       rstn = 1'b1;
    logic       Rx   = 1'b1;
    logic [7:0] O_DATA;
    logic       NrD;
    logic       FE;
    logic       RiP;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic       nrd;
        logic       fe;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         low_after;
        logic       exp_nrd;
        logic       exp_fe;
        logic [7:0] exp_data;
    } vec_t;

    ev_t        evq[$];
    bit         rip_log[int];
    logic [7:0] model_data;

    uart_rx #(.BAUD_DIVIDER(DIV)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .Rx     (Rx),
        .O_DATA (O_DATA),
        .NrD    (NrD),
        .FE     (FE),
        .RiP    (RiP)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle number: after the n-th rising edge, cyc equals n.
    always @(posedge clk) cyc <= cyc + 1;

    // Log RiP every cycle, and log every strobe together with its cycle and O_DATA.
    always @(negedge clk) begin
        ev_t e;
        rip_log[cyc] = RiP;
        if (NrD === 1'b1 || FE === 1'b1) begin
            e.cyc  = cyc;
            e.nrd  = NrD;
            e.fe   = FE;
            e.data = O_DATA;
            evq.push_back(e);
        end
    end

    // Abort the run if the bench gets stuck.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Send one frame.
    // Call this at #1 after a rising edge. Cycle c of the frame is captured
    // by the first synchroniser flop at edge t0 + c.
    task automatic applyStimulus(input logic [7:0] data, input logic stop, input int glitch_at, output int t0);
        logic [9:0] bits;
        bits = {stop, data, 1'b0};
        t0   = cyc + 1;
        for (int c = 0; c < 10 * DIV; c++) begin
            Rx = bits[c / DIV] ^ (c == glitch_at);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idleLine(input int n, input logic level);
        Rx = level;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkFrame(input string name, input int t0, input logic exp_nrd, input logic exp_fe,
                              input logic [7:0] exp_data);
        ev_t e;
        int  ev;
        ev = t0 + EV_LAT;
        checkOutput({name, " strobe present"}, evq.size() > 0, 1);
        if (evq.size() > 0) begin
            e = evq.pop_front();
            checkOutput({name, " strobe cycle"}, e.cyc, ev);
            checkOutput({name, " NrD"}, e.nrd, exp_nrd);
            checkOutput({name, " FE"}, e.fe, exp_fe);
            checkOutput({name, " O_DATA"}, e.data, exp_data);
        end
        checkOutput({name, " RiP before start"}, rip_log[t0 + 1 + EXTRA], 0);
        checkOutput({name, " RiP rise"}, rip_log[t0 + 2 + EXTRA], 1);
        checkOutput({name, " RiP at strobe"}, rip_log[ev], 1);
        checkOutput({name, " RiP after strobe"}, rip_log[ev + 1], 0);
    endtask

    initial begin
        vec_t vecs[4];
        int   t0;
        int   ta;
        int   tb;
        int   hi;
        logic [7:0] d;
        logic       s;

        vecs[0] = '{8'h55, 1'b1, 0,           1'b1, 1'b0, 8'h55};
        vecs[1] = '{8'hA3, 1'b0, 3 * 10 * DIV, 1'b0, 1'b1, 8'h55};
        vecs[2] = '{8'h80, 1'b1, 0,           1'b1, 1'b0, 8'h80};
        vecs[3] = '{8'h3F, 1'b0, 0,           1'b0, 1'b1, 8'h80};

        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset O_DATA", O_DATA, 8'h00);
        checkOutput("reset NrD", NrD, 0);
        checkOutput("reset FE", FE, 0);
        checkOutput("reset RiP", RiP, 0);
        rstn = 1'b1;
        idleLine(10, 1'b1);

        // Table-driven frames, including a held-low break after a framing error.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].data, vecs[i].stop, -1, t0);
            if (vecs[i].low_after > 0) idleLine(vecs[i].low_after, 1'b0);
            idleLine(40, 1'b1);
            checkFrame($sformatf("vec%0d", i), t0, vecs[i].exp_nrd, vecs[i].exp_fe, vecs[i].exp_data);
            checkOutput($sformatf("vec%0d extra strobes", i), evq.size(), 0);
            checkOutput($sformatf("vec%0d O_DATA hold", i), O_DATA, vecs[i].exp_data);
            evq.delete();
        end

        // A 20-cycle low glitch is a false start, and the next frame is still received.
        t0 = cyc + 1;
        idleLine(20, 1'b0);
        idleLine(150, 1'b1);
        checkOutput("glitch strobes", evq.size(), 0);
        hi = 0;
        for (int c = t0; c < t0 + 170; c++) hi += int'(rip_log[c]);
        checkOutput("glitch RiP width", hi, 2 + DIV / 2 - 1);
        evq.delete();
        applyStimulus(8'hA5, 1'b1, -1, t0);
        idleLine(20, 1'b1);
        checkFrame("after glitch A5", t0, 1'b1, 1'b0, 8'hA5);

        // Back-to-back frames with no idle gap between them.
        applyStimulus(8'h00, 1'b1, -1, ta);
        applyStimulus(8'hFF, 1'b1, -1, tb);
        idleLine(20, 1'b1);
        checkFrame("b2b 00", ta, 1'b1, 1'b0, 8'h00);
        checkFrame("b2b FF", tb, 1'b1, 1'b0, 8'hFF);
        checkOutput("b2b extra strobes", evq.size(), 0);
        evq.delete();

        // Reset pulse during data bit 4 aborts the frame. Bits 4..7 and the stop bit are high,
        // so nothing retriggers after release.
        fork
            applyStimulus(8'hF5, 1'b1, -1, ta);
            begin
                repeat (5 * DIV + 50) @(posedge clk);
                #3;
                checkOutput("RiP mid-frame", RiP, 1);
                rstn = 1'b0;
                #1;
                checkOutput("async reset O_DATA", O_DATA, 8'h00);
                checkOutput("async reset NrD", NrD, 0);
                checkOutput("async reset FE", FE, 0);
                checkOutput("async reset RiP", RiP, 0);
                repeat (3) @(posedge clk);
                #1;
                rstn = 1'b1;
            end
        join
        idleLine(50, 1'b1);
        checkOutput("reset frame strobes", evq.size(), 0);
        evq.delete();
        applyStimulus(8'h3C, 1'b1, -1, t0);
        idleLine(20, 1'b1);
        checkFrame("after reset 3C", t0, 1'b1, 1'b0, 8'h3C);
        model_data = 8'h3C;

`ifdef UART_RX_MAJORITY_EN
        // A one-cycle inverted glitch exactly at the mid-sample of bit 2 is voted out.
        applyStimulus(8'h81, 1'b1, 1 + DIV / 2 + DIV * 3, t0);
        idleLine(20, 1'b1);
        checkFrame("majority 81", t0, 1'b1, 1'b0, 8'h81);
        model_data = 8'h81;
`endif

        // Random frames against the reference model.
        for (int i = 0; i < 24; i++) begin
            d = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            applyStimulus(d, s, -1, t0);
            idleLine(s ? int'($urandom_range(0, 30)) : int'($urandom_range(3, 30)), 1'b1);
            if (s) model_data = d;
            checkFrame($sformatf("rand%0d", i), t0, s, !s, model_data);
        end
        checkOutput("final extra strobes", evq.size(), 0);
        checkOutput("final O_DATA", O_DATA, model_data);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
